bcd_to_binary: RTL and testbench

Sequential 3-digit BCD to binary converter that uses reverse double-dabble: shift right, then subtract 3 from any digit of 8 or more. It is the inverse of the team's sequential binary-to-BCD decoder. It accepts hundreds/tens/ones digits, for example from keypad or display entry logic, and returns a 10-bit binary value (0–999) over a start/done handshake. It also rejects digits above 9.

---
 rtl/bcd_to_binary_pkg.sv | 9 +
 rtl/bcd_digit_adjust.sv | 7 +
 rtl/bcd_to_binary.sv | 97 +++++++++
 tb/tb_bcd_to_binary.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_to_binary_pkg.sv
// bcd_to_binary_pkg: shared sizes, digit limit and FSM states for the BCD-to-binary converter
package bcd_to_binary_pkg;
    localparam int NUM_DIGITS = 3;
    localparam int BIN_WIDTH  = 10;
    localparam int BCD_WIDTH  = 4 * NUM_DIGITS;
    localparam int WORK_WIDTH = BCD_WIDTH + BIN_WIDTH;
    localparam logic [3:0] DIGIT_MAX = 4'd9;
    typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: reverse double-dabble correction, subtract 3 from a digit of 8 or more
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);
    always_comb digit_out = (digit_in >= 4'd8) ? digit_in - 4'd3 : digit_in;
endmodule

// File: rtl/bcd_to_binary.sv
// bcd_to_binary: sequential 3-digit BCD to 10-bit binary converter (reverse double-dabble)
module bcd_to_binary
    import bcd_to_binary_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [3:0]           hundreds,
    input  logic [3:0]           tens,
    input  logic [3:0]           ones,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [BIN_WIDTH-1:0] binary
);
    state_t                state_q, state_d;
    logic [WORK_WIDTH-1:0] work_q, work_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_pend_q, err_pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [BIN_WIDTH-1:0]  binary_q, binary_d;
    logic [WORK_WIDTH-1:0] shifted;
    logic [BCD_WIDTH-1:0]  adj_bcd;
    logic                  digit_bad;

    assign shifted   = work_q >> 1;
    assign digit_bad = (hundreds > DIGIT_MAX) || (tens > DIGIT_MAX) || (ones > DIGIT_MAX);

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in  (shifted[BIN_WIDTH + 4*d +: 4]),
            .digit_out (adj_bcd[4*d +: 4])
        );
    end

    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        err_pend_d = err_pend_q;
        done_d     = 1'b0;
        error_d    = error_q;
        binary_d   = binary_q;
        case (state_q)
            IDLE: if (start) begin
                state_d    = digit_bad ? FINISH : SHIFT;
                err_pend_d = digit_bad;
                if (!digit_bad) begin
                    work_d = {hundreds, tens, ones, {BIN_WIDTH{1'b0}}};
                    cnt_d  = 4'd0;
                end
            end
            SHIFT: begin
                work_d  = {adj_bcd, shifted[BIN_WIDTH-1:0]};
                cnt_d   = cnt_q + 4'd1;
                state_d = (cnt_q == 4'(BIN_WIDTH - 1)) ? FINISH : SHIFT;
            end
            FINISH: begin
                state_d  = IDLE;
                done_d   = 1'b1;
                error_d  = err_pend_q;
                binary_d = err_pend_q ? binary_q : work_q[BIN_WIDTH-1:0];
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            err_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            binary_q   <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            err_pend_q <= err_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            binary_q   <= binary_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign binary = binary_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// tb_bcd_to_binary: randomized and directed checks of bcd_to_binary against an arithmetic model
module tb_bcd_to_binary;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] hundreds = '0, tens = '0, ones = '0;
    logic       busy, done, error;
    logic [9:0] binary;
    int         n_cmp = 0, n_fail = 0;
    int         last_bin = 0;

    always #5 clock = ~clock;

    bcd_to_binary dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .binary   (binary)
    );

    function automatic int model_value(input int h, input int t, input int o);
        return 100 * h + 10 * t + o;
    endfunction

    // Drive one start request; returns #1 after the edge that samples it, with junk on the digits.
    task automatic start_req(input int h, input int t, input int o);
        @(negedge clock);
        start = 1'b1;
        hundreds = 4'(h);
        tens = 4'(t);
        ones = 4'(o);
        @(posedge clock);
        #1;
        start = 1'b0;
        hundreds = 4'($urandom);
        tens = 4'($urandom);
        ones = 4'($urandom);
    endtask

    // Counts edges until done is seen; gives up at 50.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 50) begin
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (binary !== 10'd0) begin n_fail++; $display("FAIL reset_binary: got %0d want 0", binary); end
        last_bin = 0;
    endtask

    task automatic test_basic;
        int lat;
        start_req(2, 5, 5);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_high: got %b want 1", busy); end
        wait_done(lat);
        n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL basic_latency: got %0d want 11", lat); end
        n_cmp++; if (binary !== 10'h0FF) begin n_fail++; $display("FAIL basic_binary: got %0d want 255", binary); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL basic_error: got %b want 0", error); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_low: got %b want 0", busy); end
        @(posedge clock);
        #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        last_bin = 255;
    endtask

    task automatic test_back_to_back;
        int lat;
        start_req(9, 9, 9);
        wait_done(lat);
        n_cmp++; if (binary !== 10'h3E7) begin n_fail++; $display("FAIL b2b_999: got %0d want 999", binary); end
        start_req(0, 0, 0);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy %b want 1", busy); end
        wait_done(lat);
        n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL b2b_latency: got %0d want 11", lat); end
        n_cmp++; if (binary !== 10'd0) begin n_fail++; $display("FAIL b2b_000: got %0d want 0", binary); end
        last_bin = 0;
    endtask

    task automatic test_error;
        int lat;
        start_req(1, 2, 8);
        wait_done(lat);
        n_cmp++; if (binary !== 10'h080) begin n_fail++; $display("FAIL err_pre_128: got %0d want 128", binary); end
        start_req(3, 10, 4);
        wait_done(lat);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL err_latency: got %0d want 1 edge after start", lat); end
        n_cmp++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b want 1", error); end
        n_cmp++; if (binary !== 10'd128) begin n_fail++; $display("FAIL err_binary_held: got %0d want 128", binary); end
        start_req(0, 0, 7);
        wait_done(lat);
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", error); end
        n_cmp++; if (binary !== 10'd7) begin n_fail++; $display("FAIL err_next_7: got %0d want 7", binary); end
        last_bin = 7;
    endtask

    task automatic test_ignore_start;
        int lat, extra;
        start_req(5, 0, 0);
        repeat (3) @(posedge clock);
        start_req(0, 0, 1);
        wait_done(lat);
        n_cmp++; if (lat !== 7) begin n_fail++; $display("FAIL ign_latency: got %0d want 7 edges after second start", lat); end
        n_cmp++; if (binary !== 10'd500) begin n_fail++; $display("FAIL ign_binary: got %0d want 500", binary); end
        extra = 0;
        repeat (15) begin
            @(posedge clock);
            #1;
            if (done) extra++;
        end
        n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL ign_single_done: got %0d extra pulses want 0", extra); end
        last_bin = 500;
    endtask

    task automatic test_reset_abort;
        int lat, seen;
        start_req(7, 6, 5);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (binary !== 10'd0) begin n_fail++; $display("FAIL abort_binary: got %0d want 0", binary); end
        n_cmp++; if (error !== 1'b0) begin n_fail++; $display("FAIL abort_error: got %b want 0", error); end
        seen = 0;
        repeat (15) begin
            @(posedge clock);
            #1;
            if (done) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        start_req(0, 4, 2);
        wait_done(lat);
        n_cmp++; if (binary !== 10'd42) begin n_fail++; $display("FAIL abort_next_42: got %0d want 42", binary); end
        last_bin = 42;
    endtask

    task automatic test_sweep;
        int lat, exp_v;
        for (int h = 0; h < 10; h++)
            for (int t = 0; t < 10; t++)
                for (int o = 0; o < 10; o++) begin
                    exp_v = model_value(h, t, o);
                    start_req(h, t, o);
                    wait_done(lat);
                    n_cmp++; if (int'(binary) !== exp_v) begin n_fail++; $display("FAIL sweep_%0d%0d%0d_value: got %0d want %0d", h, t, o, binary, exp_v); end
                    n_cmp++; if (lat !== 11) begin n_fail++; $display("FAIL sweep_%0d%0d%0d_latency: got %0d want 11", h, t, o, lat); end
                end
        last_bin = 999;
    endtask

    task automatic test_random;
        int h, t, o, lat, exp_lat, exp_bin;
        bit bad;
        for (int i = 0; i < 200; i++) begin
            h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            t = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            o = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
            bad = (h > 9) || (t > 9) || (o > 9);
            exp_bin = bad ? last_bin : model_value(h, t, o);
            exp_lat = bad ? 1 : 11;
            start_req(h, t, o);
            wait_done(lat);
            n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            n_cmp++; if (error !== bad) begin n_fail++; $display("FAIL rand_%0d_error: got %b want %b", i, error, bad); end
            n_cmp++; if (int'(binary) !== exp_bin) begin n_fail++; $display("FAIL rand_%0d_binary: got %0d want %0d", i, binary, exp_bin); end
            last_bin = exp_bin;
            repeat ($urandom_range(0, 2)) @(posedge clock);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_error;
        test_ignore_start;
        test_reset_abort;
        test_sweep;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
